// File: rtl/div_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package div_pkg;

    localparam int DW_DEF = 16;
    localparam int VW_DEF = 8;
    localparam int CW_DEF = 5;
    localparam int TW_DEF = VW_DEF + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_sub_stage.sv
// Combinational trial subtract: (VW+1)-bit partial remainder minus zero-extended divisor.
module div_sub_stage #(
    parameter int VW = 8
) (
    input  logic [VW:0]   a_i,
    input  logic [VW-1:0] d_i,
    output logic [VW:0]   diff_o,
    output logic          borrow_o
);

    // One extra bit on top catches the borrow out of the (VW+1)-bit subtract.
    assign {borrow_o, diff_o} = {1'b0, a_i} - {2'b00, d_i};

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential DW/VW unsigned restoring divider, one quotient bit per cycle.
// Optional build macro DIV_ZERO_DETECT_EN: divisor==0 short-circuits to DONE and raises div_zero.
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_zero
);

    state_t        state_q, state_d;
    logic [DW-1:0] q_q, q_d;
    logic [VW:0]   r_q, r_d;
    logic [VW-1:0] d_q, d_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] quot_q, quot_d;
    logic [VW-1:0] rem_q, rem_d;
    logic          done_q, done_d;
`ifdef DIV_ZERO_DETECT_EN
    logic          dz_q, dz_d;
`endif

    logic [VW:0]   trial;
    logic [VW:0]   diff;
    logic          borrow;

    assign trial = {r_q[VW-1:0], q_q[DW-1]};

    div_sub_stage #(.VW(VW)) u_sub (
        .a_i      (trial),
        .d_i      (d_q),
        .diff_o   (diff),
        .borrow_o (borrow)
    );

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        r_d     = r_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
`ifdef DIV_ZERO_DETECT_EN
        dz_d    = dz_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    q_d     = dividend;
                    r_d     = '0;
                    d_d     = divisor;
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef DIV_ZERO_DETECT_EN
                    dz_d    = 1'b0;
                    if (divisor == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        quot_d  = '1;
                        rem_d   = dividend[VW-1:0];
                        dz_d    = 1'b1;
                    end
`endif
                end
            end
            RUN: begin
                // Borrow means the trial went negative: keep the shifted value instead.
                r_d   = borrow ? trial : diff;
                q_d   = {q_q[DW-2:0], ~borrow};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DW - 1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    quot_d  = q_d;
                    rem_d   = r_d[VW-1:0];
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            r_q     <= r_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
`ifdef DIV_ZERO_DETECT_EN
            dz_q    <= dz_d;
`endif
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = done_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;
`ifdef DIV_ZERO_DETECT_EN
    assign div_zero  = dz_q;
`else
    assign div_zero  = 1'b0;
`endif

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench: vector table plus scoreboard, hand sequences for hold/abort/zero cases.
module tb_seq_restoring_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy, done, div_zero;
    logic [15:0] quotient;
    logic [7:0]  remainder;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    typedef struct {
        logic [15:0] dd;
        logic [7:0]  dv;
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
    } exp_t;

    typedef struct {
        logic [15:0] dd;
        logic [7:0]  dv;
        logic [15:0] q;
        logic [7:0]  r;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[9];

`ifdef DIV_ZERO_DETECT_EN
    localparam bit ZEN = 1'b1;
`else
    localparam bit ZEN = 1'b0;
`endif

    seq_restoring_divider dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [7:0] b);
        exp_t e;
        e.dd = a; e.dv = b;
        if (b == 0) begin
            e.q = 16'hFFFF; e.r = a[7:0]; e.dz = ZEN;
        end else begin
            e.q = a / b; e.r = 8'(a % b); e.dz = 1'b0;
        end
        return e;
    endfunction

    // Scoreboard: every done pops the oldest expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("sb_unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", quotient, e.q);
                chk("remainder", remainder, e.r);
                chk("div_zero", div_zero, e.dz);
                if (e.dv != 0) begin
                    chk("q*d+r", 32'(quotient) * 32'(e.dv) + 32'(remainder), 32'(e.dd));
                    chk("r<d", 32'(remainder < e.dv), 32'd1);
                end
            end
        end
    end

    task automatic run_div(input logic [15:0] a, input logic [7:0] b, input int lat, input int bcyc);
        int cyc;
        int bcnt;
        sb.push_back(model(a, b));
        start = 1'b1; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; bcnt = 0;
        while (!done && cyc < 40) begin
            if (busy) bcnt++;
            @(negedge clk);
            cyc++;
        end
        chk("latency", cyc, lat);
        chk("busy_cycles", bcnt, bcyc);
        @(negedge clk);
    endtask

    initial begin
        int dc0;
        int zl, zb;
        vecs[0] = '{16'd1000,  8'd16,  16'd62,    8'd8};
        vecs[1] = '{16'hFFFF,  8'hFF,  16'd257,   8'd0};
        vecs[2] = '{16'd5,     8'd7,   16'd0,     8'd5};
        vecs[3] = '{16'd0,     8'd1,   16'd0,     8'd0};
        vecs[4] = '{16'hFFFF,  8'd1,   16'hFFFF,  8'd0};
        vecs[5] = '{16'd1,     8'd255, 16'd0,     8'd1};
        vecs[6] = '{16'd12345, 8'd123, 16'd100,   8'd45};
        vecs[7] = '{16'd200,   8'd200, 16'd1,     8'd0};
        vecs[8] = '{16'd255,   8'd16,  16'd15,    8'd15};

        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quot", quotient, 0);
        chk("rst_rem", remainder, 0);
        chk("rst_dz", div_zero, 0);

        // Table vectors: hand-computed constants, scoreboard carries them.
        for (int i = 0; i < 9; i++) begin
            exp_t e;
            e.dd = vecs[i].dd; e.dv = vecs[i].dv; e.q = vecs[i].q; e.r = vecs[i].r; e.dz = 1'b0;
            sb.push_back(e);
            start = 1'b1; dividend = vecs[i].dd; divisor = vecs[i].dv;
            @(negedge clk);
            start = 1'b0;
            for (int c = 1; c < 40 && !done; c++) @(negedge clk);
            @(negedge clk);
        end
        chk("table_sb_empty", sb.size(), 0);

        // Latency and busy length on the reference case.
        run_div(16'd1000, 8'd16, 17, 16);

        // start held for 20 cycles: operands of cycle 0 and of the next IDLE cycle (18) are used.
        dc0 = done_cnt;
        sb.push_back(model(16'd1000, 8'd3));
        for (int i = 0; i < 20; i++) begin
            start = 1'b1; dividend = 16'(1000 + i * 37); divisor = 8'(3 + i);
            if (i == 18) sb.push_back(model(16'(1000 + 18 * 37), 8'(3 + 18)));
            @(negedge clk);
        end
        start = 1'b0;
        for (int c = 0; c < 40 && sb.size() != 0; c++) @(negedge clk);
        chk("hold_sb_empty", sb.size(), 0);
        chk("hold_done_count", done_cnt - dc0, 2);
        @(negedge clk);

        // Abort mid-RUN with reset.
        dc0 = done_cnt;
        start = 1'b1; dividend = 16'd1000; divisor = 8'd16;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_quot", quotient, 0);
        chk("abort_rem", remainder, 0);
        repeat (20) @(negedge clk);
        chk("abort_no_done", done_cnt - dc0, 0);
        run_div(16'd300, 8'd7, 17, 16);

        // Divide by zero.
        zl = ZEN ? 1 : 17;
        zb = ZEN ? 0 : 16;
        run_div(16'd1234, 8'd0, zl, zb);
        chk("dz_holds", div_zero, 32'(ZEN));
        run_div(16'd50, 8'd5, 17, 16);

        // Random pairs against the behavioural model.
        for (int i = 0; i < 300; i++) begin
            logic [15:0] a;
            logic [7:0]  b;
            a = 16'($urandom);
            b = 8'($urandom_range(1, 255));
            run_div(a, b, 17, 16);
        end
        chk("final_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
